// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared types and sizes for the register-file dump controller.
package regfile_dump_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic [2:0] {
        IDLE,
        HALT_WAIT,
        READ,
        SEND,
        FINISH
    } state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Halts the core, walks START_REG..END_REG through one regfile read port and
// streams (index, data) beats out on a valid/ready interface.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int START_REG = 0,
    parameter int END_REG   = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halted,
    output logic                 halt_req,
    output logic [REG_IDX_W-1:0] rf_a,
    input  logic [XLEN-1:0]      rf_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_IDX_W-1:0] out_idx,
    output logic [XLEN-1:0]      out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 abort
);

    localparam logic [REG_IDX_W-1:0] START_IDX = REG_IDX_W'(START_REG);
    localparam logic [REG_IDX_W-1:0] END_IDX   = REG_IDX_W'(END_REG);

    state_t               state, state_d;
    logic [REG_IDX_W-1:0] idx, idx_d;
    logic                 halt_req_d, out_valid_d, out_last_d, done_d, abort_d;
    logic [REG_IDX_W-1:0] out_idx_d;
    logic [XLEN-1:0]      out_data_d;

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        halt_req_d  = halt_req;
        out_valid_d = out_valid;
        out_idx_d   = out_idx;
        out_data_d  = out_data;
        out_last_d  = out_last;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_d      = START_IDX;
                    halt_req_d = 1'b1;
                    state_d    = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (halted) state_d = READ;
            end
            READ, SEND: begin
                // Losing the halt means the captured state can no longer be trusted.
                if (!halted) begin
                    out_valid_d = 1'b0;
                    halt_req_d  = 1'b0;
                    abort_d     = 1'b1;
                    state_d     = IDLE;
                end else if (state == READ) begin
                    out_data_d  = rf_rd;
                    out_idx_d   = idx;
                    out_last_d  = (idx == END_IDX);
                    out_valid_d = 1'b1;
                    state_d     = SEND;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = READ;
                    end
                end
            end
            FINISH: begin
                halt_req_d = 1'b0;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            halt_req  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            halt_req  <= halt_req_d;
            out_valid <= out_valid_d;
            out_idx   <= out_idx_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            done      <= done_d;
            abort     <= abort_d;
        end
    end

    assign rf_a = idx;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_regfile_dump_ctrl;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic        halted = 1'b1;
    logic        out_ready = 1'b1;

    logic        halt_req, out_valid, out_last, busy, done, abort;
    logic [4:0]  rf_a, out_idx;
    logic [31:0] rf_rd, out_data;

    logic        halt_req2, out_valid2, out_last2, busy2, done2, abort2;
    logic [4:0]  rf_a2, out_idx2;
    logic [31:0] rf_rd2, out_data2;

    logic [31:0] rf [32];
    beat_t       q[$];
    beat_t       q2[$];
    int          checks = 0, failures = 0;
    int          done_cnt = 0, abort_cnt = 0, beats2 = 0;

    always #5 clk = ~clk;

    assign rf_rd  = rf[rf_a];
    assign rf_rd2 = rf[rf_a2];

    regfile_dump_ctrl #(.XLEN(32), .START_REG(0), .END_REG(31)) dut (
        .clk(clk), .reset(reset), .start(start), .halted(halted),
        .halt_req(halt_req), .rf_a(rf_a), .rf_rd(rf_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .out_last(out_last), .busy(busy),
        .done(done), .abort(abort)
    );

    regfile_dump_ctrl #(.XLEN(32), .START_REG(5), .END_REG(5)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .halted(halted),
        .halt_req(halt_req2), .rf_a(rf_a2), .rf_rd(rf_rd2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_idx(out_idx2),
        .out_data(out_data2), .out_last(out_last2), .busy(busy2),
        .done(done2), .abort(abort2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int lo, input int hi);
        beat_t b;
        for (int i = lo; i <= hi; i++) begin
            b.idx  = 5'(i);
            b.data = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
            b.last = (i == 31);
            q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_beat(input logic [4:0] idx, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (out_valid && out_idx == idx) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Assumes beat 31 is currently presented with out_ready high.
    task automatic check_finish(input string name);
        tick();
        chk({name, "_done_early"}, 64'(done), 64'd0);
        tick();
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_halt_req_low"}, 64'(halt_req), 64'd0);
        chk({name, "_busy_low"}, 64'(busy), 64'd0);
        tick();
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_queue_empty"}, 64'(q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 64'(out_idx), 64'h3f);
            end else begin
                e = q.pop_front();
                chk("beat_idx", 64'(out_idx), 64'(e.idx));
                chk("beat_data", 64'(out_data), 64'(e.data));
                chk("beat_last", 64'(out_last), 64'(e.last));
            end
        end
        if (!reset && done) done_cnt++;
        if (!reset && abort) abort_cnt++;
    end

    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid2 && out_ready) begin
            beats2++;
            if (q2.size() == 0) begin
                chk("sub_unexpected_beat", 64'(out_idx2), 64'h3f);
            end else begin
                e = q2.pop_front();
                chk("sub_beat_idx", 64'(out_idx2), 64'(e.idx));
                chk("sub_beat_data", 64'(out_data2), 64'(e.data));
                chk("sub_beat_last", 64'(out_last2), 64'(e.last));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc, ac;
        bit   ok;
        beat_t b;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);

        // Reset values
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_halt_req", 64'(halt_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        chk("rst_fields", {out_idx, out_data, out_last, rf_a, done, abort}, 64'd0);

        // Full dump, latency 3 cycles from start to out_valid
        push_beats(0, 31);
        pulse_start();
        chk("lat_halt_req", 64'(halt_req), 64'd1);
        chk("lat_busy", 64'(busy), 64'd1);
        tick();
        chk("lat_read_no_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lat_first_valid", 64'(out_valid), 64'd1);
        wait_beat(5'd31, "full");
        check_finish("full");

        // Backpressure on idx 3
        push_beats(0, 31);
        pulse_start();
        wait_beat(5'd3, "bp");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {out_valid, out_idx, out_data}, {1'b1, 5'd3, 32'h103});
        end
        out_ready = 1'b1;
        wait_beat(5'd31, "bp");
        check_finish("bp");

        // Halt handshake delayed 10 cycles
        push_beats(0, 31);
        halted = 1'b0;
        pulse_start();
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(halt_req && busy && !out_valid)) ok = 1'b0;
            tick();
        end
        chk("hw_waiting", 64'(ok), 64'd1);
        halted = 1'b1;
        tick();
        chk("hw_no_valid_yet", 64'(out_valid), 64'd0);
        tick();
        chk("hw_first_beat", {out_valid, out_idx}, {1'b1, 5'd0});
        wait_beat(5'd31, "hw");
        check_finish("hw");

        // Halt loss during SEND of idx 7
        push_beats(0, 6);
        dc = done_cnt;
        ac = abort_cnt;
        pulse_start();
        wait_beat(5'd7, "hl");
        out_ready = 1'b0;
        halted = 1'b0;
        tick();
        chk("hl_abort", {abort, out_valid, halt_req, busy}, {1'b1, 1'b0, 1'b0, 1'b0});
        tick();
        chk("hl_abort_pulse", 64'(abort), 64'd0);
        halted = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("hl_no_more_beats", 64'(out_valid), 64'd0);
        chk("hl_no_done", 64'(done_cnt - dc), 64'd0);
        chk("hl_abort_cnt", 64'(abort_cnt - ac), 64'd1);
        chk("hl_queue_empty", 64'(q.size()), 64'd0);

        // Reset mid-dump at idx 12, then a full dump from the start
        push_beats(0, 11);
        dc = done_cnt;
        ac = abort_cnt;
        pulse_start();
        wait_beat(5'd12, "rm");
        reset = 1'b1;
        q.delete();
        #2;
        chk("rm_outputs", {halt_req, out_valid, out_idx, out_data, out_last, busy, done, abort, rf_a},
            64'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("rm_no_pulses", 64'((done_cnt - dc) + (abort_cnt - ac)), 64'd0);
        chk("rm_idle", {busy, out_valid}, 64'd0);
        push_beats(0, 31);
        pulse_start();
        wait_beat(5'd0, "rm_restart");
        chk("rm_restart_first", 64'(out_idx), 64'd0);
        wait_beat(5'd31, "rm_restart");
        check_finish("rm_restart");

        // Single-register range with a second start while busy
        b.idx = 5'd5; b.data = 32'h105; b.last = 1'b1;
        q2.push_back(b);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("sub_done_seen", 64'(ok), 64'd1);
        repeat (8) tick();
        chk("sub_one_beat", 64'(beats2), 64'd1);
        chk("sub_idle", {busy2, out_valid2, halt_req2}, 64'd0);
        chk("sub_queue_empty", 64'(q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
